// File: rtl/pool_pkg.sv
// Shared types and defaults for the KxK pooling layer.
// The POOL_AVG_EN build macro selects whether average pooling is compiled in;
// the package itself is identical in both builds.
package pool_pkg;

    // Default element width, two's-complement signed
    localparam int POOL_DATA_W = 16;

    // Pooling operation applied to a window
    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    // One feature-map element at the default width
    typedef logic signed [POOL_DATA_W-1:0] pool_elem_t;

    // Top-level control states: collecting columns, or holding a pooled column
    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } pool_state_e;

    // log2 of the legal window sizes (2 -> 1, 4 -> 2)
    function automatic int pool_log2k(input int k);
        return (k == 4) ? 2 : 1;
    endfunction

endpackage

// File: rtl/pool_layer_kxk_if.sv
// Column-stream interface for pool_layer_kxk: input column handshake on one
// side, pooled column handshake on the other. The block is the slave.
interface pool_layer_kxk_if #(
    parameter int ROWS   = 24,
    parameter int DATA_W = 16,
    parameter int POOL_K = 2
);
    localparam int OUT_ROWS = ROWS / POOL_K;

    logic                               mode_avg;
    logic                               sof_in;
    logic                               valid_in;
    logic                               ready_in;
    logic [ROWS-1:0][DATA_W-1:0]        input_column;
    logic                               valid_out;
    logic                               ready_out;
    logic [OUT_ROWS-1:0][DATA_W-1:0]    output_column;

    modport slave (
        input  mode_avg, sof_in, valid_in, input_column, ready_out,
        output ready_in, valid_out, output_column
    );

    modport master (
        output mode_avg, sof_in, valid_in, input_column, ready_out,
        input  ready_in, valid_out, output_column
    );

endinterface

// File: rtl/pool_window_unit.sv
// Per-output-row window accumulator. Each transferred column contributes
// POOL_K vertically adjacent elements; first_i starts a fresh window so no
// state from a previous window survives. res_o is the window result including
// the column presented this cycle, so the top can register it on the last one.
// Build macro POOL_AVG_EN adds the widened sum path and the floor shift.
module pool_window_unit
    import pool_pkg::*;
#(
    parameter int DATA_W = POOL_DATA_W,
    parameter int POOL_K = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           load_i,
    input  logic                           first_i,
`ifdef POOL_AVG_EN
    input  logic                           mode_avg_i,
`endif
    input  logic [POOL_K-1:0][DATA_W-1:0]  elems_i,
    output logic [DATA_W-1:0]              res_o
);

`ifdef POOL_AVG_EN
    localparam int SH    = 2 * pool_log2k(POOL_K);
    localparam int ACC_W = DATA_W + SH;
`else
    localparam int ACC_W = DATA_W;
`endif

    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [DATA_W-1:0] col_max_s;
    logic signed [ACC_W-1:0]  max_ext_s;

    // Signed maximum of this column's POOL_K elements
    always_comb begin
        col_max_s = $signed(elems_i[0]);
        for (int i = 1; i < POOL_K; i++) begin
            if ($signed(elems_i[i]) > col_max_s) begin
                col_max_s = $signed(elems_i[i]);
            end else begin
                col_max_s = col_max_s;
            end
        end
        max_ext_s = ACC_W'(col_max_s);
    end

`ifdef POOL_AVG_EN
    logic signed [ACC_W-1:0] col_sum_s;

    // Sum of this column's elements, widened so the full window cannot overflow
    always_comb begin
        col_sum_s = '0;
        for (int i = 0; i < POOL_K; i++) begin
            col_sum_s = col_sum_s + ACC_W'($signed(elems_i[i]));
        end
    end

    // Window update for the column on offer, and the resulting pooled value
    always_comb begin
        acc_d = acc_q;
        if (mode_avg_i) begin
            if (first_i) begin
                acc_d = col_sum_s;
            end else begin
                acc_d = acc_q + col_sum_s;
            end
            res_o = DATA_W'(acc_d >>> SH);
        end else begin
            if (first_i || (max_ext_s > acc_q)) begin
                acc_d = max_ext_s;
            end else begin
                acc_d = acc_q;
            end
            res_o = DATA_W'(acc_d);
        end
    end
`else
    // Window update for the column on offer, and the resulting pooled value
    always_comb begin
        acc_d = acc_q;
        if (first_i || (max_ext_s > acc_q)) begin
            acc_d = max_ext_s;
        end else begin
            acc_d = acc_q;
        end
        res_o = DATA_W'(acc_d);
    end
`endif

    // Accumulator register, advanced only on a column transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (load_i) begin
            acc_q <= acc_d;
        end else begin
            acc_q <= acc_q;
        end
    end

endmodule

// File: rtl/pool_layer_kxk.sv
// KxK max/average pooling over a stream of feature-map columns. POOL_K
// consecutive columns form one window; each output row pools a POOL_K-row
// slice of them. Output appears one cycle after the window's last column and
// is held until accepted; a new window may start in the draining cycle.
// Build macro POOL_AVG_EN enables average mode; without it mode_avg is ignored.
module pool_layer_kxk
    import pool_pkg::*;
#(
    parameter int ROWS   = 24,
    parameter int DATA_W = POOL_DATA_W,
    parameter int POOL_K = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    pool_layer_kxk_if.slave bus
);

    localparam int OUT_ROWS = ROWS / POOL_K;
    localparam int PH_W     = pool_log2k(POOL_K);

    pool_state_e                      state_q;
    pool_state_e                      state_d;
    logic [PH_W-1:0]                  phase_q;
    logic [PH_W-1:0]                  phase_d;
    logic [PH_W-1:0]                  cur_phase_s;
    logic                             ready_in_s;
    logic                             xfer_s;
    logic                             first_s;
    logic                             last_s;
    logic [OUT_ROWS-1:0][DATA_W-1:0]  res_s;
    logic [OUT_ROWS-1:0][DATA_W-1:0]  out_q;

    // Handshake and position of the offered column within its window
    always_comb begin
        ready_in_s = (!rst_n) || (state_q == ST_ACC) || bus.ready_out;
        xfer_s     = bus.valid_in && ready_in_s;
        if (bus.sof_in) begin
            cur_phase_s = '0;
        end else begin
            cur_phase_s = phase_q;
        end
        first_s = (cur_phase_s == '0);
        last_s  = (cur_phase_s == PH_W'(POOL_K - 1));
        if (xfer_s) begin
            if (last_s) begin
                phase_d = '0;
            end else begin
                phase_d = cur_phase_s + PH_W'(1);
            end
        end else begin
            phase_d = phase_q;
        end
    end

    // Next state: ACC -> OUT on window completion, OUT -> ACC once drained
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC: begin
                if (xfer_s && last_s) begin
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_OUT: begin
                if (bus.ready_out) begin
                    if (xfer_s && last_s) begin
                        state_d = ST_OUT;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    // State, phase and pooled-column registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            phase_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            if (xfer_s && last_s) begin
                out_q <= res_s;
            end else begin
                out_q <= out_q;
            end
        end
    end

`ifdef POOL_AVG_EN
    pool_mode_e mode_q;
    pool_mode_e mode_eff_s;
    logic       mode_avg_s;

    // Mode for the offered column: live input at window start, latched after
    always_comb begin
        if (first_s) begin
            mode_eff_s = bus.mode_avg ? POOL_AVG : POOL_MAX;
        end else begin
            mode_eff_s = mode_q;
        end
        mode_avg_s = (mode_eff_s == POOL_AVG);
    end

    // Latch the window's mode when its first column transfers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= POOL_MAX;
        end else if (xfer_s && first_s) begin
            mode_q <= mode_eff_s;
        end else begin
            mode_q <= mode_q;
        end
    end
`else
    logic unused_mode_s;
    assign unused_mode_s = bus.mode_avg;
`endif

    for (genvar j = 0; j < OUT_ROWS; j++) begin : g_row
        pool_window_unit #(
            .DATA_W (DATA_W),
            .POOL_K (POOL_K)
        ) u_win (
            .clk        (clk),
            .rst_n      (rst_n),
            .load_i     (xfer_s),
            .first_i    (first_s),
`ifdef POOL_AVG_EN
            .mode_avg_i (mode_avg_s),
`endif
            .elems_i    (bus.input_column[POOL_K*j +: POOL_K]),
            .res_o      (res_s[j])
        );
    end

    assign bus.ready_in      = ready_in_s;
    assign bus.valid_out     = (state_q == ST_OUT);
    assign bus.output_column = out_q;

endmodule

// File: tb/tb_pool_layer_kxk.sv
// Bench for pool_layer_kxk: a K=2 (24 rows) and a K=4 (8 rows) instance,
// directed scenarios plus random streams, checked against a window model.
module tb_pool_layer_kxk;
    import pool_pkg::*;

`ifdef POOL_AVG_EN
    localparam bit AVG_BUILD = 1'b1;
`else
    localparam bit AVG_BUILD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pool_layer_kxk_if #(.ROWS(24), .DATA_W(16), .POOL_K(2)) b2 ();
    pool_layer_kxk_if #(.ROWS(8),  .DATA_W(16), .POOL_K(4)) b4 ();

    pool_layer_kxk #(.ROWS(24), .DATA_W(16), .POOL_K(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    pool_layer_kxk #(.ROWS(8),  .DATA_W(16), .POOL_K(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    int           n_tests = 0;
    int           n_fail  = 0;
    int           mw[2][4][24];
    int           mn[2];
    bit           mm[2];
    logic [255:0] exp_v[2];
    bit           exp_pend[2];
    int           drains[2];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pooled column from a complete window, straight from the definition
    function automatic logic [255:0] ref_pool(input int win[4][24], input int k, input int rows, input bit avg);
        logic [255:0] v;
        longint sum;
        int best;
        int res;
        int n;
        v = '0;
        n = k * k;
        for (int j = 0; j < rows / k; j++) begin
            sum  = 0;
            best = win[0][k*j];
            for (int c = 0; c < k; c++) begin
                for (int r = 0; r < k; r++) begin
                    sum += win[c][k*j+r];
                    if (win[c][k*j+r] > best) best = win[c][k*j+r];
                end
            end
            if (avg) res = int'((sum >= 0) ? sum / n : -((-sum + n - 1) / n));
            else     res = best;
            v[j*16 +: 16] = 16'(res);
        end
        return v;
    endfunction

    task automatic rand_col(output int c[24]);
        pool_elem_t e;
        for (int r = 0; r < 24; r++) begin
            e = pool_elem_t'($urandom);
            c[r] = int'(e);
        end
    endtask

    // One clock cycle on instance id: drive, check against model, update model
    task automatic cyc(input int id, input bit v, input bit sof, input bit mode, input int c[24], input bit rdy);
        int k;
        int rows;
        logic [255:0] got;
        bit vo;
        bit ri;
        bit pend;
        bit xfer;
        k    = (id == 0) ? 2 : 4;
        rows = (id == 0) ? 24 : 8;
        if (id == 0) begin
            b2.valid_in = v; b2.sof_in = sof; b2.mode_avg = mode; b2.ready_out = rdy;
            for (int r = 0; r < 24; r++) b2.input_column[r] = 16'(c[r]);
        end else begin
            b4.valid_in = v; b4.sof_in = sof; b4.mode_avg = mode; b4.ready_out = rdy;
            for (int r = 0; r < 8; r++) b4.input_column[r] = 16'(c[r]);
        end
        #1;
        if (id == 0) begin
            got = 256'(b2.output_column); vo = b2.valid_out; ri = b2.ready_in;
        end else begin
            got = 256'(b4.output_column); vo = b4.valid_out; ri = b4.ready_in;
        end
        pend = exp_pend[id];
        chk($sformatf("valid_out[k%0d]", k), 256'(vo), 256'(pend));
        chk($sformatf("ready_in[k%0d]", k), 256'(ri), 256'(!pend || rdy));
        if (pend) chk($sformatf("output_column[k%0d]", k), got, exp_v[id]);
        xfer = v && (!pend || rdy);
        if (pend && rdy) begin
            exp_pend[id] = 1'b0;
            drains[id]++;
        end
        if (xfer) begin
            if (sof) mn[id] = 0;
            if (mn[id] == 0) mm[id] = mode;
            for (int r = 0; r < 24; r++) mw[id][mn[id]][r] = c[r];
            mn[id]++;
            if (mn[id] == k) begin
                exp_v[id]    = ref_pool(mw[id], k, rows, AVG_BUILD && mm[id]);
                exp_pend[id] = 1'b1;
                mn[id]       = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        b2.valid_in = 1'b0; b4.valid_in = 1'b0;
        b2.ready_out = 1'b1; b4.ready_out = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_valid_k2", 256'(b2.valid_out), 256'(0));
        chk("rst_ready_k2", 256'(b2.ready_in), 256'(1));
        chk("rst_out_k2", 256'(b2.output_column), 256'(0));
        chk("rst_valid_k4", 256'(b4.valid_out), 256'(0));
        chk("rst_ready_k4", 256'(b4.ready_in), 256'(1));
        chk("rst_out_k4", 256'(b4.output_column), 256'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mn[i] = 0; exp_pend[i] = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        int ca[24];
        int cb[24];
        int cc[24];
        int d0;
        b2.valid_in = 1'b0; b2.sof_in = 1'b0; b2.mode_avg = 1'b0; b2.ready_out = 1'b1; b2.input_column = '0;
        b4.valid_in = 1'b0; b4.sof_in = 1'b0; b4.mode_avg = 1'b0; b4.ready_out = 1'b1; b4.input_column = '0;
        for (int i = 0; i < 2; i++) begin
            mn[i] = 0; mm[i] = 1'b0; exp_pend[i] = 1'b0; exp_v[i] = '0; drains[i] = 0;
        end
        @(negedge clk);
        do_reset();

        // Max pooling, K=2: row0 window {1,5,3,-2} -> 5, valid one cycle later
        rand_col(ca); ca[0] = 1; ca[1] = 5;
        rand_col(cb); cb[0] = 3; cb[1] = -2;
        cyc(0, 1'b1, 1'b1, 1'b0, ca, 1'b1);
        cyc(0, 1'b1, 1'b0, 1'b0, cb, 1'b1);
        #1;
        chk("max_latency_valid", 256'(b2.valid_out), 256'(1));
        chk("max_row0", 256'(b2.output_column[0]), 256'(16'd5));
        cyc(0, 1'b0, 1'b0, 1'b0, ca, 1'b1);

        // Average (or max when average is not built): {1,2,3,-7}
        rand_col(ca); ca[0] = 1; ca[1] = 2;
        rand_col(cb); cb[0] = 3; cb[1] = -7;
        cyc(0, 1'b1, 1'b1, 1'b1, ca, 1'b1);
        cyc(0, 1'b1, 1'b0, 1'b1, cb, 1'b1);
        #1;
        chk("avg_row0", 256'(b2.output_column[0]), AVG_BUILD ? 256'(16'hFFFF) : 256'(16'd3));
        cyc(0, 1'b0, 1'b0, 1'b0, ca, 1'b1);

        // Back-pressure: output held 5 cycles with a column waiting, then drain+accept
        d0 = drains[0];
        rand_col(ca); rand_col(cb); rand_col(cc);
        cyc(0, 1'b1, 1'b1, 1'b0, ca, 1'b1);
        cyc(0, 1'b1, 1'b0, 1'b0, cb, 1'b1);
        for (int i = 0; i < 5; i++) cyc(0, 1'b1, 1'b0, 1'b1, cc, 1'b0);
        cyc(0, 1'b1, 1'b0, 1'b1, cc, 1'b1);
        rand_col(ca);
        cyc(0, 1'b1, 1'b0, 1'b0, ca, 1'b1);
        cyc(0, 1'b0, 1'b0, 1'b0, ca, 1'b1);
        chk("stall_outputs", 256'(drains[0] - d0), 256'(2));

        // K=4: sof on the 3rd column drops the partial window
        d0 = drains[1];
        for (int i = 0; i < 7; i++) begin
            rand_col(ca);
            cyc(1, 1'b1, (i == 0) || (i == 2), 1'b0, ca, 1'b1);
        end
        cyc(1, 1'b0, 1'b0, 1'b0, ca, 1'b1);
        chk("sof_k4_outputs", 256'(drains[1] - d0), 256'(1));

        // Reset in phase 1, then a clean window
        rand_col(ca);
        cyc(0, 1'b1, 1'b1, 1'b0, ca, 1'b1);
        do_reset();
        d0 = drains[0];
        rand_col(ca); rand_col(cb);
        cyc(0, 1'b1, 1'b0, 1'b0, ca, 1'b1);
        cyc(0, 1'b1, 1'b0, 1'b0, cb, 1'b1);
        cyc(0, 1'b0, 1'b0, 1'b0, ca, 1'b1);
        chk("reset_then_window", 256'(drains[0] - d0), 256'(1));

        // Random streams on both instances
        for (int id = 0; id < 2; id++) begin
            d0 = drains[id];
            for (int i = 0; i < 400; i++) begin
                rand_col(ca);
                cyc(id, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 1'($urandom), ca, $urandom_range(0, 3) != 0);
            end
            cyc(id, 1'b0, 1'b0, 1'b0, ca, 1'b1);
            chk($sformatf("random_outputs_seen[%0d]", id), 256'(drains[id] > d0 + 10), 256'(1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
